mux_rr_stream: RTL and testbench
================================

MUX_RR_STREAM -- requirements
Module: mux_rr_stream

Interface
REQ-001 Parameter: N, default 4, number of input channels, legal range 2..16.
REQ-002 Parameter: WIDTH, default 8, data bits per channel and for the output.
REQ-003 Derived constant: SEL_W = max(1, clog2(N)), not user-overridable.
REQ-004 Port: clk  in  1  single clock, all state on its rising edge.
REQ-005 Port: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 Port: mode  in  1  0 = fixed select, 1 = round-robin scan.
REQ-007 Port: sel  in  SEL_W  channel index used in fixed mode.
REQ-008 Port: in_valid  in  N  per-channel data valid.
REQ-009 Port: in_data  in  N*WIDTH  packed; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-010 Port: in_ready  out  N  per-channel accept, at most one bit high (one-hot or zero).
REQ-011 Port: out_valid  out  1  output register holds an item.
REQ-012 Port: out_data  out  WIDTH  selected data.
REQ-013 Port: out_ch  out  SEL_W  index of the channel that supplied out_data.
REQ-014 Port: out_ready  in  1  downstream accept.

Function
REQ-015 load_en = !out_valid || out_ready; no transfer occurs when load_en = 0.
REQ-016 Fixed mode: grant = sel only when sel < N and in_valid[sel] = 1; otherwise there is no grant.
REQ-017 Fixed mode: sel >= N never grants, and all in_ready bits stay 0.
REQ-018 Round-robin mode: grant = first channel with in_valid = 1, searching from last_grant+1 upward and wrapping from N-1 to 0.
REQ-019 in_ready[i] = load_en && (grant == i); in_ready is combinational from in_valid, mode, sel, out_valid, out_ready and last_grant.
REQ-020 Transfer on channel i: out_data <= in_data[i], out_ch <= i, out_valid <= 1 at the next edge, giving a latency of 1 cycle.
REQ-021 last_grant <= i on every transfer in either mode; last_grant is otherwise held.
REQ-022 Pop (out_valid && out_ready) with no transfer in the same cycle: out_valid <= 0, and out_data and out_ch hold their values.
REQ-023 Pop and transfer in the same cycle: both occur, and the new item is loaded.
REQ-024 Sustained throughput is 1 item per cycle.
REQ-025 Backpressure (out_valid && !out_ready): out_valid, out_data and out_ch remain stable until the pop.
REQ-026 Changes to mode or sel affect only the next grant; an item already in the output register is unaffected.
REQ-027 No item is duplicated or dropped; each input transfer produces exactly one output pop.

Reset
REQ-028 While rst_n = 0: out_valid = 0, out_data = 0, out_ch = 0, last_grant = N-1, and in_ready = 0.
REQ-029 Reset asserted mid-operation discards the held item immediately (asynchronously).
REQ-030 After reset release, the first round-robin grant searches from channel 0.

Structure
REQ-031 Package mux_rr_pkg holds the MODE_FIXED = 1'b0 and MODE_RR = 1'b1 constants.
REQ-032 A single sub-module, rr_arbiter (combinational rotating-priority grant from req[N] and last_grant), is instantiated once.
REQ-033 The datapath register and load logic stay in mux_rr_stream.

Verification (N=4, WIDTH=8)
REQ-034 Fixed mode: sel=2, in_data ch2=0x5A, all valid, out_ready=1 -> in_ready=4'b0100; next cycle out_data=0x5A, out_ch=2.
REQ-035 Round-robin, all 4 valid, out_ready=1, data ch i = 0x10+i -> out_ch sequence 0,1,2,3,0; out_data 0x10,0x11,0x12,0x13,0x10.
REQ-036 Round-robin, only ch1 and ch3 valid -> grants alternate 1,3,1,3 with no gap cycles.
REQ-037 Backpressure: out_ready=0 for 3 cycles after load of 0x33 -> out_data stays 0x33, in_ready=0; on out_ready=1, the next item loads in the same cycle.
REQ-038 Reset mid-stream: rst_n=0 while out_valid=1 -> out_valid=0 with no clock edge; after release, a round-robin burst with all valid starts at ch0.
REQ-039 Parameter sweep: N=3, sel=3 in fixed mode -> in_ready=0, out_valid stays 0.

Source files
------------

// File: rtl/mux_rr_pkg.sv
// Shared constants for the round-robin / fixed-select stream multiplexer.
package mux_rr_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Channel-index width, never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority grant: first requester above last_grant, wrapping at N-1.
module rr_arbiter
    import mux_rr_pkg::*;
#(
    parameter  int unsigned N     = 4,
    localparam int unsigned SEL_W = sel_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] last_grant,
    output logic             grant_valid,
    output logic [SEL_W-1:0] grant
);

    int unsigned idx;

    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        idx         = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (32'(last_grant) + k) % N;
            if (!grant_valid && req[idx[SEL_W-1:0]]) begin
                grant_valid = 1'b1;
                grant       = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mux_rr_stream.sv
// N-to-1 stream multiplexer with fixed or round-robin channel selection
// and a single registered output stage.
module mux_rr_stream
    import mux_rr_pkg::*;
#(
    parameter  int unsigned N     = 4,
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned SEL_W = sel_width(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     sel,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_ch,
    input  logic                 out_ready
);

    logic [SEL_W-1:0] last_grant;
    logic [SEL_W-1:0] rr_grant;
    logic             rr_valid;
    logic [SEL_W-1:0] grant;
    logic             grant_valid;
    logic             load_en;
    logic [WIDTH-1:0] grant_data;

    rr_arbiter #(.N(N)) u_arb (
        .req         (in_valid),
        .last_grant  (last_grant),
        .grant_valid (rr_valid),
        .grant       (rr_grant)
    );

    // Grant selection; an out-of-range sel in fixed mode matches no channel.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        if (mode == MODE_RR) begin
            grant_valid = rr_valid;
            grant       = rr_grant;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (32'(sel) == i && in_valid[i]) begin
                    grant_valid = 1'b1;
                    grant       = SEL_W'(i);
                end
            end
        end
    end

    // Holding reset keeps in_ready low even though the output stage is empty.
    always_comb begin
        load_en    = rst_n && (!out_valid || out_ready);
        in_ready   = '0;
        grant_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (32'(grant) == i) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
            in_ready[i] = load_en && grant_valid && (32'(grant) == i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            last_grant <= SEL_W'(N - 1);
        end else if (load_en && grant_valid) begin
            out_valid  <= 1'b1;
            out_data   <= grant_data;
            out_ch     <= grant;
            last_grant <= grant;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_rr_stream.sv
// Bench for mux_rr_stream: directed scenarios plus randomized traffic against a
// transaction-level model; a second N=3 instance covers the out-of-range select.
module tb_mux_rr_stream;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mode = 1'b0;
    logic [1:0]    sel = '0;
    logic [N-1:0]  in_valid = '0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]  in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [1:0]    out_ch;
    logic          out_ready = 1'b0;

    logic          mode3 = 1'b0;
    logic [1:0]    sel3 = 2'd3;
    logic [2:0]    in_valid3 = '0;
    logic [3*W-1:0] in_data3 = '0;
    logic [2:0]    in_ready3;
    logic          out_valid3;
    logic [W-1:0]  out_data3;
    logic [1:0]    out_ch3;
    logic          out_ready3 = 1'b1;

    int errors = 0;
    int checks = 0;

    // Reference model state: output register contents and last granted channel.
    int        m_lg;
    bit        m_ov;
    logic [7:0] m_od;
    int        m_oc;
    int        hist[$];

    always #5 clk = ~clk;

    mux_rr_stream #(.N(N), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
        .out_ready(out_ready)
    );

    mux_rr_stream #(.N(3), .WIDTH(W)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
        .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
        .out_valid(out_valid3), .out_data(out_data3), .out_ch(out_ch3),
        .out_ready(out_ready3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_lg = N - 1;
        m_ov = 1'b0;
        m_od = 8'h00;
        m_oc = 0;
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_ch", 32'(out_ch), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        model_reset();
        in_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: check registered outputs, drive inputs, check in_ready, advance model.
    task automatic cycle(input logic md, input logic [1:0] s, input logic [3:0] v,
                         input logic [31:0] d, input logic ordy);
        int  g;
        bit  load;
        logic [31:0] exp_ready;
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("out_data", 32'(out_data), 32'(m_od));
        chk("out_ch", 32'(out_ch), 32'(m_oc));
        mode = md; sel = s; in_valid = v; in_data = d; out_ready = ordy;
        #1;
        g = -1;
        load = !m_ov || ordy;
        if (md == 1'b0) begin
            if (int'(s) < N && v[s]) g = int'(s);
        end else begin
            for (int k = 1; k <= N; k++) begin
                if (g < 0 && v[(m_lg + k) % N]) g = (m_lg + k) % N;
            end
        end
        exp_ready = (load && g >= 0) ? (32'd1 << g) : 32'd0;
        chk("in_ready", 32'(in_ready), exp_ready);
        if (load && g >= 0) begin
            m_ov = 1'b1;
            m_od = d[g*8 +: 8];
            m_oc = g;
            m_lg = g;
            hist.push_back(g);
        end else if (m_ov && ordy) begin
            m_ov = 1'b0;
        end
    endtask

    initial begin
        model_reset();
        do_reset();

        // Fixed select of channel 2.
        cycle(1'b0, 2'd2, 4'hF, 32'h4D5A3C2B, 1'b1);
        chk("fix_ready", 32'(in_ready), 32'h4);
        @(posedge clk); #1;
        chk("fix_data", 32'(out_data), 32'h5A);
        chk("fix_ch", 32'(out_ch), 2);

        // Round-robin from reset: 0,1,2,3,0.
        do_reset();
        hist.delete();
        for (int i = 0; i < 5; i++) cycle(1'b1, 2'd0, 4'hF, 32'h13121110, 1'b1);
        for (int i = 0; i < 5; i++) chk("rr_seq", 32'(hist[i]), 32'(i % 4));
        @(posedge clk); #1;
        chk("rr_last_data", 32'(out_data), 32'h10);

        // Only channels 1 and 3 requesting: alternate with no gaps.
        hist.delete();
        for (int i = 0; i < 4; i++) cycle(1'b1, 2'd0, 4'b1010, 32'h13121110, 1'b1);
        for (int i = 0; i < 4; i++) chk("rr_alt", 32'(hist[i]), (i % 2 == 0) ? 32'd1 : 32'd3);

        // Backpressure: hold 0x33 for three cycles, then pop and reload together.
        cycle(1'b0, 2'd1, 4'b0010, 32'h00003300, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 2'd2, 4'hF, 32'h00440000, 1'b0);
            chk("bp_ready", 32'(in_ready), 0);
        end
        @(posedge clk); #1;
        chk("bp_hold", 32'(out_data), 32'h33);
        cycle(1'b0, 2'd2, 4'hF, 32'h00440000, 1'b1);
        chk("bp_release_ready", 32'(in_ready), 32'h4);
        cycle(1'b0, 2'd0, 4'h0, 32'h0, 1'b1);
        chk("bp_new_item", 32'(out_data), 32'h44);

        // Reset while holding an item, then a round-robin burst restarts at 0.
        cycle(1'b1, 2'd0, 4'hF, 32'h13121110, 1'b0);
        cycle(1'b1, 2'd0, 4'hF, 32'h13121110, 1'b0);
        do_reset();
        hist.delete();
        for (int i = 0; i < 3; i++) cycle(1'b1, 2'd0, 4'hF, 32'h23222120, 1'b1);
        chk("post_rst_first", 32'(hist[0]), 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) != 0));
        end

        // N=3 instance: select 3 never grants, select 2 does.
        mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; in_data3 = 24'h332211; out_ready3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("n3_ready", 32'(in_ready3), 0);
            chk("n3_out_valid", 32'(out_valid3), 0);
        end
        sel3 = 2'd2;
        #1;
        chk("n3_sel2_ready", 32'(in_ready3), 32'h4);
        @(negedge clk);
        chk("n3_sel2_data", 32'(out_data3), 32'h33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
